// File: rtl/counter_mod_n_ud.sv
// Modulo-N up/down counter with run-time modulus, synchronous load/clear and one-shot mode.
// tc is combinational for cascading; wrap and done are registered.
`timescale 1ns/1ps
module counter_mod_n_ud #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] tUp;
  logic [WIDTH-1:0] termVal;
  logic             atTerm;
  logic             outOfRange;

  // n = 0 gives tUp = 2^WIDTH-1 through natural underflow, i.e. full range.
  assign tUp        = n - WIDTH'(1);
  assign termVal    = up ? tUp : '0;
  assign atTerm     = (q_q == termVal);
  assign outOfRange = (n != '0) && (q_q >= n);

  assign q    = q_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign tc   = en & atTerm & ~done_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = ((n == '0) || (d < n)) ? d : tUp;
      done_d = 1'b0;
    end else if (en) begin
      if (oneshot && done_q) begin
        q_d = q_q;
      end else if (oneshot && atTerm) begin
        done_d = 1'b1;
      end else if (oneshot && up && outOfRange) begin
        // Modulus shrank below the count: finish at the new top instead of wrapping.
        q_d    = tUp;
        done_d = 1'b1;
      end else if (up) begin
        if (atTerm || outOfRange) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if ((q_q == '0) || outOfRange) begin
          q_d    = tUp;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_counter_mod_n_ud.sv
// Directed bench for counter_mod_n_ud: reset, continuous up/down, full range,
// one-shot, load/clear priority and run-time modulus changes.
`timescale 1ns/1ps
module tb_counter_mod_n_ud;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       clr;
  logic       load;
  logic [7:0] d;
  logic       oneshot;
  logic [7:0] n;
  logic [7:0] q;
  logic       tc;
  logic       wrap;
  logic       done;

  int vectors;
  int miscompares;

  counter_mod_n_ud #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .d(d), .oneshot(oneshot), .n(n), .q(q), .tc(tc), .wrap(wrap), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it before anything is sampled.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int expQ;
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
    d = 8'd0; oneshot = 1'b0; n = 8'd10;

    // Reset state
    applyStimulus();
    applyStimulus();
    checkOutput("reset_q", q, 0);
    checkOutput("reset_wrap", wrap, 0);
    checkOutput("reset_done", done, 0);

    // Count to 5, then async reset mid-count
    rst = 1'b1;
    applyStimulus();
    en = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("pre_reset_q", q, 5);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_q", q, 0);
    checkOutput("async_reset_wrap", wrap, 0);
    applyStimulus();
    checkOutput("held_reset_q", q, 0);
    rst = 1'b1;
    applyStimulus();
    checkOutput("first_count_q", q, 1);

    // Continuous up, n = 10, 25 cycles from 0
    en = 1'b0; clr = 1'b1;
    applyStimulus();
    clr = 1'b0; en = 1'b1;
    expQ = 0;
    for (int i = 0; i < 25; i++) begin
      checkOutput("cont_up_tc", tc, (expQ == 9) ? 1 : 0);
      applyStimulus();
      checkOutput("cont_up_wrap", wrap, (expQ == 9) ? 1 : 0);
      expQ = (expQ + 1) % 10;
      checkOutput("cont_up_q", q, expQ);
    end
    checkOutput("cont_up_final_q", q, 5);

    // Continuous down from 0 wraps to n-1
    en = 1'b0; clr = 1'b1;
    applyStimulus();
    clr = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    checkOutput("down_tc_at_0", tc, 1);
    applyStimulus();
    checkOutput("down_wrap_q", q, 9);
    checkOutput("down_wrap_pulse", wrap, 1);
    applyStimulus();
    checkOutput("down_step_q", q, 8);
    checkOutput("down_wrap_cleared", wrap, 0);

    // Full range n = 0: 255 -> 0 with wrap
    en = 1'b0; n = 8'd0; load = 1'b1; d = 8'd255;
    applyStimulus();
    load = 1'b0;
    checkOutput("full_load_q", q, 255);
    up = 1'b1; en = 1'b1;
    #1;
    checkOutput("full_tc", tc, 1);
    applyStimulus();
    checkOutput("full_wrap_q", q, 0);
    checkOutput("full_wrap_pulse", wrap, 1);

    // One-shot, n = 4: 0,1,2,3,3,3
    en = 1'b0; n = 8'd4; oneshot = 1'b1; clr = 1'b1;
    applyStimulus();
    clr = 1'b0; en = 1'b1;
    applyStimulus();
    checkOutput("os_q1", q, 1);
    applyStimulus();
    checkOutput("os_q2", q, 2);
    applyStimulus();
    checkOutput("os_q3", q, 3);
    checkOutput("os_done_pre", done, 0);
    checkOutput("os_tc_at_3", tc, 1);
    applyStimulus();
    checkOutput("os_hold_q", q, 3);
    checkOutput("os_done", done, 1);
    checkOutput("os_no_wrap", wrap, 0);
    checkOutput("os_tc_masked", tc, 0);
    applyStimulus();
    checkOutput("os_hold_q2", q, 3);
    checkOutput("os_done_sticky", done, 1);
    load = 1'b1; d = 8'd1;
    applyStimulus();
    load = 1'b0;
    checkOutput("os_reload_q", q, 1);
    checkOutput("os_reload_done", done, 0);
    applyStimulus();
    checkOutput("os_resume_q", q, 2);

    // Load saturation and priority
    oneshot = 1'b0; n = 8'd10; en = 1'b0; load = 1'b1; d = 8'd200;
    applyStimulus();
    checkOutput("load_sat_q", q, 9);
    clr = 1'b1; d = 8'd3;
    applyStimulus();
    checkOutput("clr_over_load_q", q, 0);
    clr = 1'b0; en = 1'b1;
    applyStimulus();
    checkOutput("load_over_en_q", q, 3);
    load = 1'b0;
    applyStimulus();
    checkOutput("after_load_step_q", q, 4);

    // Run-time modulus shrink, continuous
    en = 1'b0; load = 1'b1; d = 8'd8;
    applyStimulus();
    load = 1'b0;
    checkOutput("shrink_start_q", q, 8);
    n = 8'd5; en = 1'b1;
    applyStimulus();
    checkOutput("shrink_cont_q", q, 0);
    checkOutput("shrink_cont_wrap", wrap, 1);

    // Run-time modulus shrink, one-shot
    en = 1'b0; n = 8'd10; load = 1'b1; d = 8'd8;
    applyStimulus();
    load = 1'b0;
    n = 8'd5; oneshot = 1'b1; en = 1'b1;
    applyStimulus();
    checkOutput("shrink_os_q", q, 4);
    checkOutput("shrink_os_done", done, 1);
    applyStimulus();
    checkOutput("shrink_os_hold_q", q, 4);

    // n = 1 continuous: stays at 0, wraps every cycle
    oneshot = 1'b0; n = 8'd1; en = 1'b0; clr = 1'b1;
    applyStimulus();
    clr = 1'b0; en = 1'b1;
    #1;
    checkOutput("n1_tc", tc, 1);
    applyStimulus();
    checkOutput("n1_q", q, 0);
    checkOutput("n1_wrap_a", wrap, 1);
    applyStimulus();
    checkOutput("n1_wrap_b", wrap, 1);

    // en low: hold and clear wrap
    en = 1'b0;
    applyStimulus();
    checkOutput("hold_wrap", wrap, 0);
    checkOutput("hold_q", q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_mod_n_ud.md
# counter_mod_n_ud

Parametrised modulo-N counter with a run-time modulus, up/down direction, synchronous load and clear, and a continuous or one-shot mode. Provides a combinational terminal-count output for cascading, a registered wrap pulse and a sticky done flag. Serves as the general-purpose counter for timers, dividers and sequencers across the design.

## Interface
- WIDTH, 8, counter and modulus width in bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; one step per enabled cycle
- up  in  1  direction: 1 = count up, 0 = count down
- clr  in  1  synchronous clear
- load  in  1  synchronous load of d
- d  in  WIDTH  load value
- oneshot  in  1  mode: 1 = stop at terminal value, 0 = wrap continuously
- n  in  WIDTH  modulus; counter range 0..n-1; n = 0 means full range 2^WIDTH
- q  out  WIDTH  count value
- tc  out  1  terminal count, combinational
- wrap  out  1  registered one-cycle pulse on each wrap
- done  out  1  registered sticky flag, one-shot completion

## Operation
- Terminal value T: up → n-1 (2^WIDTH-1 if n = 0); down → 0.
- tc = en & (q == T) & ~done. Purely combinational from q, n, up, en, done; no clr/load term.
- Per-cycle priority: clr > load > count > hold.
- clr: q ← 0, done ← 0, wrap ← 0.
- load: q ← d if d < n (or n = 0), else q ← n-1 (saturate); done ← 0; wrap ← 0.
- Count, continuous mode (oneshot = 0, en = 1):
  - up: q == T or q ≥ n (n ≠ 0) → q ← 0, wrap ← 1; else q ← q+1.
  - down: q == 0 or q ≥ n (n ≠ 0) → q ← T_up (n-1), wrap ← 1; else q ← q-1.
- Count, one-shot mode (oneshot = 1, en = 1):
  - done = 1 → q holds; en ignored.
  - q == T → q holds, done ← 1, wrap ← 0.
  - q ≥ n while counting up (n changed at run time) → q ← n-1, done ← 1.
  - Otherwise same step as continuous mode.
- en = 0: q and done hold; wrap ← 0.
- n = 1: q stays at 0. Continuous mode with en = 1: wrap = 1 every cycle, tc = 1.
- A change of n takes effect on the next edge. No state besides q, wrap and done.
- Switching oneshot or up between cycles is legal and uses the current value.
- All arithmetic is WIDTH bits, unsigned. n = 0 uses natural overflow (2^WIDTH-1 → 0 and 0 → 2^WIDTH-1).

## Timing
- Reset (rst = 0, asynchronous): q = 0, wrap = 0, done = 0 immediately. These values hold while rst is low.
- Reset release is sampled on the next rising clk edge. First count occurs on the first edge with rst = 1 and en = 1.
- Reset mid-count or mid-one-shot aborts the operation; no wrap or done results.
- q latency: one cycle from en/load/clr to the new q.
- tc asserts in the same cycle as q == T. Used with en for cascading: the next stage's en = this stage's tc.
- wrap asserts high in the cycle after the wrapping edge, for exactly one cycle per wrap.
- done asserts in the cycle after the terminal edge and stays high until clr, load or reset.
- Simultaneous clr and load → clear wins. Simultaneous load and en → load wins; no count step that cycle.

## Test plan
- Reset and hold:
  - Stimulus: WIDTH = 8, rst low mid-count at q = 5.
  - Response: q = 0, wrap = 0, done = 0 asynchronously. After release, en = 1 gives q = 1 after one edge.
- Continuous up:
  - Stimulus: n = 10, up = 1, en = 1 for 25 cycles from 0.
  - Response: q runs 0..9,0..9,0..4. tc high when q = 9. wrap pulses twice, each one cycle after the 9→0 edge.
- Continuous down and full range:
  - Stimulus: n = 10, up = 0, start q = 0.
  - Response: the next edge gives q = 9 with wrap pulse.
  - Stimulus: n = 0, up = 1, start q = 255.
  - Response: q = 0 with wrap pulse.
- One-shot:
  - Stimulus: n = 4, oneshot = 1, up = 1.
  - Response: q = 0,1,2,3,3,3. done = 1 from the cycle after reaching 3. tc low once done = 1.
  - Stimulus: load, d = 1.
  - Response: q = 1, done = 0, counting resumes.
- Load and priority:
  - Stimulus: n = 10, load with d = 200.
  - Response: q = 9.
  - Stimulus: clr and load with d = 3 in the same cycle.
  - Response: q = 0.
  - Stimulus: load with d = 3 and en = 1.
  - Response: q = 3, no step.
- Run-time modulus shrink:
  - Stimulus: q = 8, n changed 10→5, continuous up.
  - Response: next edge q = 0 with wrap pulse.
  - Stimulus: same in one-shot mode.
  - Response: q = 4, done = 1.
